// File: rtl/uart_word_serializer.sv
// Word FIFO feeding a UART byte stream, MSB first; `UART_WORD_SERIALIZER_HEX_ASCII_EN selects hex-ASCII + CR/LF framing.
// Latency: first byte valid one cycle after the word lands; bytes hold on !byte_rdy_i, word_rdy_o drops only when full.
module uart_word_serializer #(
    parameter int UART_DATA_WIDTH = 8,
    parameter int WORD_BYTES      = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  word_val_i,
    input  logic [UART_DATA_WIDTH*WORD_BYTES-1:0] word_i,
    output logic                                  word_rdy_o,
    output logic                                  byte_val_o,
    output logic [UART_DATA_WIDTH-1:0]            byte_o,
    input  logic                                  byte_rdy_i,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_level_o,
    output logic                                  busy_o
);
    localparam int W     = UART_DATA_WIDTH * WORD_BYTES;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef UART_WORD_SERIALIZER_HEX_ASCII_EN
    localparam int N_OUT = 2 * WORD_BYTES + 2;
`else
    localparam int N_OUT = WORD_BYTES;
`endif
    localparam int IDX_W = $clog2(N_OUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic [W-1:0]               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]           level_q;
    state_t                     state_q;
    logic [W-1:0]               shreg_q;
    logic [IDX_W-1:0]           idx_q;
    logic [UART_DATA_WIDTH-1:0] byte_q;

    logic         fifo_empty, push, pop, hs, last_byte;
    logic [W-1:0] head;

    // Output character number i of word w.
    function automatic logic [UART_DATA_WIDTH-1:0] encode(input logic [W-1:0] w,
                                                          input logic [IDX_W-1:0] i);
        logic [W-1:0] t;
`ifdef UART_WORD_SERIALIZER_HEX_ASCII_EN
        logic [3:0] nib;
        t   = w << (4 * i);
        nib = t[W-1 -: 4];
        if (i == IDX_W'(2 * WORD_BYTES))
            return UART_DATA_WIDTH'(8'h0D);
        else if (i > IDX_W'(2 * WORD_BYTES))
            return UART_DATA_WIDTH'(8'h0A);
        else
            return UART_DATA_WIDTH'((nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib}));
`else
        t = w << (UART_DATA_WIDTH * i);
        return t[W-1 -: UART_DATA_WIDTH];
`endif
    endfunction

    assign fifo_empty   = (level_q == '0);
    assign word_rdy_o   = (level_q != LVL_W'(FIFO_DEPTH));
    assign push         = word_val_i && word_rdy_o;
    assign hs           = (state_q == SEND) && byte_rdy_i;
    assign last_byte    = (idx_q == LAST_IDX);
    assign pop          = !fifo_empty && ((state_q == IDLE) || (hs && last_byte));
    assign head         = mem_q[rd_ptr_q];
    assign fifo_level_o = level_q;
    assign byte_val_o   = (state_q == SEND);
    assign byte_o       = byte_q;
    assign busy_o       = !fifo_empty || (state_q != IDLE);

    // Storage carries no reset: contents are only meaningful under level_q.
    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= word_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg_q <= head;
                        idx_q   <= '0;
                        byte_q  <= encode(head, '0);
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (!last_byte) begin
                            idx_q  <= idx_q + IDX_W'(1);
                            byte_q <= encode(shreg_q, idx_q + IDX_W'(1));
                        end else if (!fifo_empty) begin
                            // Back-to-back words: reload on the last handshake, no idle gap.
                            shreg_q <= head;
                            idx_q   <= '0;
                            byte_q  <= encode(head, '0);
                        end else begin
                            shreg_q <= '0;
                            idx_q   <= '0;
                            byte_q  <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_word_serializer.sv
// Randomized bench for uart_word_serializer against a queue-based cycle model.
// Honours `UART_WORD_SERIALIZER_HEX_ASCII_EN the same way the design does.
module tb_uart_word_serializer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        word_val_i = 1'b0;
    logic [31:0] word_i = '0;
    logic        word_rdy_o;
    logic        byte_val_o;
    logic [7:0]  byte_o;
    logic        byte_rdy_i = 1'b0;
    logic [2:0]  fifo_level_o;
    logic        busy_o;

    uart_word_serializer #(.UART_DATA_WIDTH(8), .WORD_BYTES(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .word_val_i(word_val_i), .word_i(word_i),
        .word_rdy_o(word_rdy_o), .byte_val_o(byte_val_o), .byte_o(byte_o),
        .byte_rdy_i(byte_rdy_i), .fifo_level_o(fifo_level_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_fifo[$];
    logic [7:0]  m_cur[$];
    logic [7:0]  enc_buf[$];
    logic [7:0]  got[$];
    logic [7:0]  exp_stream[$];
    bit          m_act = 1'b0;
    int          rdy_mode = 0;   // 0 hold, 1 toggle, 2 random

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic encode_word(input logic [31:0] w);
        logic [3:0] n;
        enc_buf.delete();
`ifdef UART_WORD_SERIALIZER_HEX_ASCII_EN
        for (int i = 7; i >= 0; i--) begin
            n = 4'(w >> (4 * i));
            enc_buf.push_back((n < 10) ? 8'(48 + n) : 8'(55 + n));
        end
        enc_buf.push_back(8'h0D);
        enc_buf.push_back(8'h0A);
`else
        n = 4'h0;
        for (int i = 3; i >= 0; i--)
            enc_buf.push_back(8'(w >> (8 * i)));
`endif
    endtask

    task automatic model_load(input logic [31:0] w);
        encode_word(w);
        m_cur = enc_buf;
        m_act = 1'b1;
    endtask

    task automatic step();
        bit hs, push;
        hs   = m_act && byte_rdy_i;
        push = word_val_i && (m_fifo.size() != DEPTH);
        if (byte_val_o && byte_rdy_i)
            got.push_back(byte_o);
        if (rst_i) begin
            m_fifo.delete(); m_cur.delete(); m_act = 1'b0;
            got.delete(); exp_stream.delete();
        end else begin
            if (m_act) begin
                if (hs) begin
                    void'(m_cur.pop_front());
                    if (m_cur.size() == 0) begin
                        if (m_fifo.size() > 0) model_load(m_fifo.pop_front());
                        else m_act = 1'b0;
                    end
                end
            end else if (m_fifo.size() > 0) begin
                model_load(m_fifo.pop_front());
            end
            if (push) begin
                m_fifo.push_back(word_i);
                encode_word(word_i);
                foreach (enc_buf[i]) exp_stream.push_back(enc_buf[i]);
            end
        end
        @(posedge clk);
        #1;
        check_eq("byte_val", 32'(byte_val_o), 32'(m_act));
        check_eq("byte", 32'(byte_o), m_act ? 32'(m_cur[0]) : 32'h0);
        check_eq("level", 32'(fifo_level_o), 32'(m_fifo.size()));
        check_eq("word_rdy", 32'(word_rdy_o), 32'(m_fifo.size() != DEPTH));
        check_eq("busy", 32'(busy_o), 32'(m_act || m_fifo.size() > 0));
        case (rdy_mode)
            1: byte_rdy_i = ~byte_rdy_i;
            2: byte_rdy_i = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    task automatic push_word(input logic [31:0] w, input int budget);
        bit done;
        done = 1'b0;
        word_val_i = 1'b1;
        word_i = w;
        for (int k = 0; k < budget && !done; k++) begin
            done = (m_fifo.size() != DEPTH);
            step();
        end
        word_val_i = 1'b0;
        word_i = $urandom;
        if (!done) check_eq("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && (m_act || m_fifo.size() > 0); k++)
            step();
        if (m_act || m_fifo.size() > 0) check_eq("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_len"}, 32'(got.size()), 32'(exp_stream.size()));
        foreach (exp_stream[i])
            if (i < got.size()) check_eq(tag, 32'(got[i]), 32'(exp_stream[i]));
        got.delete();
        exp_stream.delete();
    endtask

    task automatic check_literal(input string tag, input logic [7:0] lit[$]);
        check_eq({tag, "_len"}, 32'(got.size()), 32'(lit.size()));
        foreach (lit[i])
            if (i < got.size()) check_eq(tag, 32'(got[i]), 32'(lit[i]));
    endtask

    initial begin
        logic [7:0] lit[$];
        int guard;

        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();

        // Basic word, ready held high
        rdy_mode = 0; byte_rdy_i = 1'b1;
        push_word(32'h11223344, 4);
        drain(40);
`ifdef UART_WORD_SERIALIZER_HEX_ASCII_EN
        lit = '{8'h31, 8'h31, 8'h32, 8'h32, 8'h33, 8'h33, 8'h34, 8'h34, 8'h0D, 8'h0A};
`else
        lit = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
        check_literal("raw_1122", lit);
        check_stream("s_basic");

        // Alternating ready
        rdy_mode = 1; byte_rdy_i = 1'b1;
        push_word(32'hA5C30F96, 4);
        drain(60);
`ifdef UART_WORD_SERIALIZER_HEX_ASCII_EN
        lit = '{8'h41, 8'h35, 8'h43, 8'h33, 8'h30, 8'h46, 8'h39, 8'h36, 8'h0D, 8'h0A};
`else
        lit = '{8'hA5, 8'hC3, 8'h0F, 8'h96};
`endif
        check_literal("bp_a5c3", lit);
        check_stream("s_bp");

        // Encoding of a mostly-zero word with letters
        rdy_mode = 0; byte_rdy_i = 1'b1;
        push_word(32'h0000BEEF, 4);
        drain(40);
`ifdef UART_WORD_SERIALIZER_HEX_ASCII_EN
        lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
`else
        lit = '{8'h00, 8'h00, 8'hBE, 8'hEF};
`endif
        check_literal("beef", lit);
        check_stream("s_beef");

        // Fill the FIFO while the UART stalls, then release
        rdy_mode = 0; byte_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) push_word($urandom, 4);
        check_eq("full_level", 32'(fifo_level_o), 32'd4);
        check_eq("full_rdy", 32'(word_rdy_o), 32'd0);
        word_val_i = 1'b1; word_i = 32'hCAFE0006;
        for (int i = 0; i < 3; i++) step();
        byte_rdy_i = 1'b1;
        push_word(32'hCAFE0006, 40);
        drain(200);
        check_stream("s_full");

        // Reset in the middle of a word
        rdy_mode = 0; byte_rdy_i = 1'b1;
        push_word(32'hDEADBEEF, 4);
        guard = 0;
        while (got.size() < 2 && guard < 20) begin step(); guard++; end
        check_eq("rst_two_bytes", 32'(got.size()), 32'd2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_eq("rst_val", 32'(byte_val_o), 32'd0);
        check_eq("rst_level", 32'(fifo_level_o), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check_eq("rst_no_resume", 32'(got.size()), 32'd0);

        // Twelve sequential words with random ready: pointers wrap three times
        rdy_mode = 2;
        for (int i = 1; i <= 12; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
            push_word(32'(i), 100);
        end
        drain(400);
        check_stream("s_wrap");

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            for (int g = $urandom_range(0, 6); g > 0; g--) step();
            push_word($urandom, 100);
        end
        drain(1000);
        check_stream("s_rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
